rgb_fade_stepper: RTL and testbench



---
 rtl/rgb_pkg.sv | 36 +++
 rtl/fade_tick_gen.sv | 29 ++
 rtl/rgb_fade_stepper.sv | 151 +++++++++++++++
 tb/tb_rgb_fade_stepper.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB fade sequencer.
package rgb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        EVAL      = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam int unsigned NUM_CH  = 3;
    localparam int unsigned CH_W    = 2;
    localparam int unsigned LEVEL_W = 8;

    typedef logic [CH_W-1:0]    ch_t;
    typedef logic [LEVEL_W-1:0] level_t;

    localparam ch_t CH_R = CH_W'(0);
    localparam ch_t CH_G = CH_W'(1);
    localparam ch_t CH_B = CH_W'(2);

    // Move cur toward tgt by at most step, using the external subtractor's cur-tgt result.
    function automatic level_t step_level(level_t cur, level_t tgt, level_t diff,
                                          logic bout, level_t step);
        level_t mag;
        mag = bout ? level_t'(~diff + level_t'(1)) : diff;
        if (!bout && (diff == '0)) begin
            return cur;
        end
        if (mag <= step) begin
            return tgt;
        end
        return bout ? level_t'(cur + step) : level_t'(cur - step);
    endfunction

endpackage

// File: rtl/fade_tick_gen.sv
// Down-counter pacing the gap between fade evaluation passes; expire_c marks the last wait cycle.
module fade_tick_gen #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= RELOAD;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expire_c = en && (cnt_q == '0);

endmodule

// File: rtl/rgb_fade_stepper.sv
// Steps current RGB levels toward their targets, one channel per cycle through a shared subtractor.
module rgb_fade_stepper
    import rgb_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned STEP     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] tgt_r_in,
    input  logic [7:0] tgt_g_in,
    input  logic [7:0] tgt_b_in,
    output logic [7:0] cur_r,
    output logic [7:0] cur_g,
    output logic [7:0] cur_b,
    output logic       busy,
    output logic       done,
    output logic [7:0] sub_a,
    output logic [7:0] sub_b,
    output logic       sub_cin,
    input  logic [7:0] sub_diff,
    input  logic       sub_bout
);

    localparam level_t STEP_L = level_t'(STEP);

    state_t state_q, state_d;
    ch_t    ch_q, ch_d;
    level_t cur_q [NUM_CH];
    level_t tgt_q [NUM_CH];
    logic   busy_q, done_q, load_ready_q;

    logic   accept_c;
    logic   load_en, upd_en, all_eq;
    logic   tick_clr, tick_en, tick_exp;
    level_t upd_val;

    fade_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tick_clr),
        .en       (tick_en),
        .expire_c (tick_exp)
    );

    assign accept_c = load_valid && load_ready_q;

    // Subtractor operands follow the selected channel; ch rests at R outside EVAL.
    assign sub_a   = cur_q[ch_q];
    assign sub_b   = tgt_q[ch_q];
    assign sub_cin = 1'b1;

    assign upd_val = step_level(cur_q[ch_q], tgt_q[ch_q], sub_diff, sub_bout, STEP_L);
    assign all_eq  = (cur_q[CH_R] == tgt_q[CH_R]) && (cur_q[CH_G] == tgt_q[CH_G]) &&
                     (upd_val == tgt_q[CH_B]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        load_en  = 1'b0;
        upd_en   = 1'b0;
        tick_clr = 1'b0;
        tick_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    load_en  = 1'b1;
                    tick_clr = 1'b1;
                    state_d  = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (accept_c) begin
                    load_en  = 1'b1;
                    tick_clr = 1'b1;
                end else begin
                    tick_en = 1'b1;
                    if (tick_exp) begin
                        state_d = EVAL;
                        ch_d    = CH_R;
                    end
                end
            end
            EVAL: begin
                upd_en = 1'b1;
                if (ch_q == CH_B) begin
                    ch_d = CH_R;
                    if (all_eq) begin
                        state_d = DONE;
                    end else begin
                        state_d  = WAIT_TICK;
                        tick_clr = 1'b1;
                    end
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and status registers; status flags are decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q         <= CH_R;
            cur_q        <= '{default: '0};
            tgt_q        <= '{default: '0};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            ch_q         <= ch_d;
            busy_q       <= (state_d != IDLE);
            done_q       <= (state_d == DONE);
            load_ready_q <= (state_d == IDLE) || (state_d == WAIT_TICK);
            if (load_en) begin
                tgt_q[CH_R] <= tgt_r_in;
                tgt_q[CH_G] <= tgt_g_in;
                tgt_q[CH_B] <= tgt_b_in;
            end
            if (upd_en) begin
                cur_q[ch_q] <= upd_val;
            end
        end
    end

    assign cur_r      = cur_q[CH_R];
    assign cur_g      = cur_q[CH_G];
    assign cur_b      = cur_q[CH_B];
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_ready = load_ready_q;

endmodule

// File: tb/tb_rgb_fade_stepper.sv
// Self-checking bench for rgb_fade_stepper: pass-level model plus directed literal checkpoints.
module tb_rgb_fade_stepper;

    localparam int T    = 4;
    localparam int STEP = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] tgt_r_in = '0, tgt_g_in = '0, tgt_b_in = '0;
    logic [7:0] cur_r, cur_g, cur_b;
    logic       busy, done;
    logic [7:0] sub_a, sub_b;
    logic       sub_cin;
    logic [7:0] sub_diff;
    logic       sub_bout;

    // Behavioural stand-in for the sibling ripple subtractor
    assign sub_diff = sub_a - sub_b;
    assign sub_bout = (sub_a < sub_b);

    rgb_fade_stepper #(.TICK_DIV(T), .STEP(STEP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .tgt_r_in   (tgt_r_in),
        .tgt_g_in   (tgt_g_in),
        .tgt_b_in   (tgt_b_in),
        .cur_r      (cur_r),
        .cur_g      (cur_g),
        .cur_b      (cur_b),
        .busy       (busy),
        .done       (done),
        .sub_a      (sub_a),
        .sub_b      (sub_b),
        .sub_cin    (sub_cin),
        .sub_diff   (sub_diff),
        .sub_bout   (sub_bout)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 0;
    bit lo_chk = 0;
    int rel    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act != exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Model: cycles since pass start decide which channel moves; levels use plain integer math.
    int  m_cur[3] = '{0, 0, 0};
    int  m_tgt[3] = '{0, 0, 0};
    int  m_since  = 0;
    bit  m_busy   = 0;
    bit  m_done   = 0;

    function automatic int approach(input int c, input int t);
        if (t > c) return (t - c <= STEP) ? t : c + STEP;
        if (c > t) return (c - t <= STEP) ? t : c - STEP;
        return c;
    endfunction

    function automatic bit m_ready();
        return !m_done && (!m_busy || m_since < T);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cur = '{0, 0, 0};
            m_tgt = '{0, 0, 0};
            m_since = 0;
            m_busy = 0;
            m_done = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (load_valid && m_ready()) begin
            m_tgt = '{int'(tgt_r_in), int'(tgt_g_in), int'(tgt_b_in)};
            m_busy = 1;
            m_since = 0;
        end else if (m_busy) begin
            m_since++;
            if (m_since >= T + 1) begin
                m_cur[m_since-T-1] = approach(m_cur[m_since-T-1], m_tgt[m_since-T-1]);
                if (m_since == T + 3) begin
                    if (m_cur[0] == m_tgt[0] && m_cur[1] == m_tgt[1] && m_cur[2] == m_tgt[2]) begin
                        m_busy = 0;
                        m_done = 1;
                    end else begin
                        m_since = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int ch;
            ch = (m_busy && m_since >= T && m_since <= T + 2) ? m_since - T : 0;
            chk("cur_r", int'(cur_r), m_cur[0]);
            chk("cur_g", int'(cur_g), m_cur[1]);
            chk("cur_b", int'(cur_b), m_cur[2]);
            chk("busy", int'(busy), int'(m_busy || m_done));
            chk("done", int'(done), int'(m_done));
            chk("load_ready", int'(load_ready), int'(m_ready()));
            chk("sub_a", int'(sub_a), m_cur[ch]);
            chk("sub_b", int'(sub_b), m_tgt[ch]);
            chk("sub_cin", int'(sub_cin), 1);
            if (lo_chk) begin
                chk("floor_r", int'(cur_r >= 8'h05), 1);
                chk("floor_g", int'(cur_g >= 8'h05), 1);
                chk("floor_b", int'(cur_b >= 8'h05), 1);
            end
        end
    end

    task automatic goto(input int e);
        while (rel < e) begin
            @(posedge clk);
            rel++;
        end
        #1;
    endtask

    task automatic do_load(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        bit ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (load_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("load_ready_timeout", 0, 1);
        tgt_r_in = r;
        tgt_g_in = g;
        tgt_b_in = b;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        rel = 0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1;
        chk("rst_cur_r", int'(cur_r), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_load_ready", int'(load_ready), 1);
        chk("rst_sub_cin", int'(sub_cin), 1);
        chk("rst_sub_a", int'(sub_a), 0);
        chk("rst_sub_b", int'(sub_b), 0);

        // Rise from zero
        do_load(8'h20, 8'h00, 8'hFF);
        goto(5);   chk("t1_r_p1", int'(cur_r), 8'h10);
        goto(7);   chk("t1_b_p1", int'(cur_b), 8'h10);
        goto(12);  chk("t1_r_p2", int'(cur_r), 8'h20);
        goto(105); chk("t1_b_p15", int'(cur_b), 8'hF0);
        goto(111); chk("t1_done_early", int'(done), 0);
        goto(112); chk("t1_done", int'(done), 1);
        chk("t1_b_final", int'(cur_b), 8'hFF);
        goto(113); chk("t1_done_once", int'(done), 0);
        chk("t1_busy_end", int'(busy), 0);

        // Descent from full scale
        do_load(8'hFF, 8'hFF, 8'hFF);
        wait_done(200);
        chk("t2_full", int'(cur_g), 8'hFF);
        do_load(8'h05, 8'h05, 8'h05);
        lo_chk = 1;
        goto(5);   chk("t2_r_p1", int'(cur_r), 8'hEF);
        goto(110); chk("t2_r_p16", int'(cur_r), 8'h05);
        goto(111); chk("t2_g_p16", int'(cur_g), 8'h05);
        goto(112); chk("t2_done", int'(done), 1);
        chk("t2_b_final", int'(cur_b), 8'h05);
        lo_chk = 0;

        // Retarget while waiting for a tick
        do_load(8'h00, 8'h00, 8'h00);
        wait_done(50);
        do_load(8'h80, 8'h00, 8'h00);
        goto(26);  chk("t3_r_at40", int'(cur_r), 8'h40);
        goto(29);
        do_load(8'h00, 8'h00, 8'h00);
        goto(4);   chk("t3_hold", int'(cur_r), 8'h40);
        chk("t3_sub_b", int'(sub_b), 8'h00);
        goto(5);   chk("t3_r_30", int'(cur_r), 8'h30);
        goto(26);  chk("t3_r_00", int'(cur_r), 8'h00);
        goto(28);  chk("t3_done", int'(done), 1);

        // Request held across EVAL is deferred, not lost
        do_load(8'h30, 8'h30, 8'h30);
        goto(4);
        chk("t4_ready_eval", int'(load_ready), 0);
        tgt_r_in = 8'h00;
        tgt_g_in = 8'h00;
        tgt_b_in = 8'h00;
        load_valid = 1'b1;
        goto(5);   chk("t4_r_old_tgt", int'(cur_r), 8'h10);
        goto(6);   chk("t4_sub_b_kept", int'(sub_b), 8'h30);
        goto(7);   chk("t4_ready_wait", int'(load_ready), 1);
        goto(8);
        load_valid = 1'b0;
        goto(13);  chk("t4_r_new", int'(cur_r), 8'h00);
        goto(15);  chk("t4_done", int'(done), 1);

        // Asynchronous reset between R and G updates
        do_load(8'h40, 8'h40, 8'h40);
        goto(5);
        chk("t5_r_pre", int'(cur_r), 8'h10);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_r", int'(cur_r), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_ready", int'(load_ready), 1);
        chk("t5_rst_done", int'(done), 0);
        #1 rst_n = 1'b1;
        do_load(8'h08, 8'h00, 8'h00);
        goto(5);   chk("t5_r_after", int'(cur_r), 8'h08);
        goto(7);   chk("t5_done", int'(done), 1);
        goto(9);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
